// File: rtl/ram_sdp_be_pkg.sv
// rtl/ram_sdp_be_pkg.sv - shared types and parameter legality helpers for ram_sdp_be
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 2;
    localparam int WFIRST_OLD = 0;
    localparam int WFIRST_NEW = 1;

    function automatic bit lat_ok(input int lat);
        return (lat == LAT_MIN) || (lat == LAT_MAX);
    endfunction

    function automatic bit lanes_ok(input int d, input int b);
        return (b > 0) && ((d % b) == 0);
    endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// rtl/ram_sdp_be_if.sv - write/read/clear port bundle for ram_sdp_be
interface ram_sdp_be_if #(
    parameter int A = 10,
    parameter int D = 8,
    parameter int B = 8
);
    localparam int L = D / B;

    logic         we;
    logic [A-1:0] waddr;
    logic [D-1:0] wdata;
    logic [L-1:0] wbe;
    logic         re;
    logic [A-1:0] raddr;
    logic [D-1:0] rdata;
    logic         rvalid;
    logic         clr;
    logic         busy;

    modport master (
        output we, waddr, wdata, wbe, re, raddr, clr,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  we, waddr, wdata, wbe, re, raddr, clr,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/ram_sdp_core.sv
// rtl/ram_sdp_core.sv - bare storage array with byte-lane write and registered read
module ram_sdp_core
    import ram_pkg::*;
#(
    parameter int A      = 10,
    parameter int D      = 8,
    parameter int B      = 8,
    parameter int WFIRST = 1
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic [A-1:0]   i_waddr,
    input  logic [D-1:0]   i_wdata,
    input  logic [D/B-1:0] i_wbe,
    input  logic           i_re,
    input  logic [A-1:0]   i_raddr,
    output logic [D-1:0]   o_rdata
);
    localparam int L = D / B;

    logic [D-1:0] r_mem [2**A];
    logic [D-1:0] w_merged;

    // Word as it will look after this edge's write; only used for same-address new-data reads
    always_comb begin
        w_merged = r_mem[i_waddr];
        for (int i = 0; i < L; i++) begin
            if (i_wbe[i]) begin
                w_merged[i*B +: B] = i_wdata[i*B +: B];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < L; i++) begin
            if (i_we && i_wbe[i]) begin
                r_mem[i_waddr][i*B +: B] <= i_wdata[i*B +: B];
            end
        end
        if (i_re) begin
            if ((WFIRST == WFIRST_NEW) && i_we && (i_raddr == i_waddr)) begin
                o_rdata <= w_merged;
            end else begin
                o_rdata <= r_mem[i_raddr];
            end
        end
    end
endmodule

// File: rtl/ram_sdp_be.sv
// rtl/ram_sdp_be.sv - simple dual-port byte-enable RAM with clear engine and 1/2-cycle read latency
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int           A      = 10,
    parameter int           D      = 8,
    parameter int           B      = 8,
    parameter int           LAT    = 1,
    parameter int           WFIRST = 1,
    parameter logic [D-1:0] FILL   = '0
) (
    input  logic        clk,
    input  logic        reset_n,
    ram_sdp_be_if.slave bus
);
    localparam int           L    = D / B;
    localparam logic [A-1:0] LAST = '1;

    if (!lanes_ok(D, B)) begin : g_bad_lanes
        $error("ram_sdp_be: D must be a non-zero multiple of B");
    end
    if (!lat_ok(LAT)) begin : g_bad_lat
        $error("ram_sdp_be: LAT must be 1 or 2");
    end

    state_t       r_state, w_state_nxt;
    logic [A-1:0] r_faddr, w_faddr_nxt;
    logic         w_we, w_re;
    logic [A-1:0] w_waddr;
    logic [D-1:0] w_wdata;
    logic [L-1:0] w_wbe;
    logic [D-1:0] w_core_rdata;
    logic         r_v1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_CLEAR;
            r_faddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_faddr <= w_faddr_nxt;
        end
    end

    // The clear engine owns the write port while active; user traffic is dropped, not queued
    always_comb begin
        w_state_nxt = r_state;
        w_faddr_nxt = r_faddr;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_waddr     = bus.waddr;
        w_wdata     = bus.wdata;
        w_wbe       = bus.wbe;
        case (r_state)
            ST_CLEAR: begin
                w_we        = 1'b1;
                w_waddr     = r_faddr;
                w_wdata     = FILL;
                w_wbe       = '1;
                w_faddr_nxt = r_faddr + 1'b1;
                if (r_faddr == LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_we = bus.we;
                w_re = bus.re;
                if (bus.clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_faddr_nxt = '0;
                end
            end
        endcase
    end

    assign bus.busy = (r_state == ST_CLEAR);

    ram_sdp_core #(
        .A      (A),
        .D      (D),
        .B      (B),
        .WFIRST (WFIRST)
    ) u_core (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_wbe   (w_wbe),
        .i_re    (w_re),
        .i_raddr (bus.raddr),
        .o_rdata (w_core_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_re;
        end
    end

    if (LAT == 2) begin : g_lat2
        logic         r_v2;
        logic [D-1:0] r_rdata2;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_v2     <= 1'b0;
                r_rdata2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_rdata2 <= w_core_rdata;
                end
            end
        end

        assign bus.rvalid = r_v2;
        assign bus.rdata  = r_rdata2;
    end else begin : g_lat1
        // The array read register has no reset, so mask it until a read has actually landed
        logic r_have;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_have <= 1'b0;
            end else if (w_re) begin
                r_have <= 1'b1;
            end
        end

        assign bus.rvalid = r_v1;
        assign bus.rdata  = r_have ? w_core_rdata : '0;
    end
endmodule

// File: tb/tb_ram_sdp_be.sv
// tb/tb_ram_sdp_be.sv - self-checking bench for ram_sdp_be with two latency/read-mode variants
module tb_ram_sdp_be;

    localparam logic [15:0] FILL_A = 16'hA5A5;
    localparam logic [15:0] FILL_B = 16'h5A3C;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we, re, clr;
    logic [3:0]  waddr, raddr;
    logic [15:0] wdata;
    logic [1:0]  wbe;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_sdp_be_if #(.A(4), .D(16), .B(8)) bus_a ();
    ram_sdp_be_if #(.A(4), .D(16), .B(8)) bus_b ();

    assign bus_a.we = we;    assign bus_b.we = we;
    assign bus_a.waddr = waddr; assign bus_b.waddr = waddr;
    assign bus_a.wdata = wdata; assign bus_b.wdata = wdata;
    assign bus_a.wbe = wbe;  assign bus_b.wbe = wbe;
    assign bus_a.re = re;    assign bus_b.re = re;
    assign bus_a.raddr = raddr; assign bus_b.raddr = raddr;
    assign bus_a.clr = clr;  assign bus_b.clr = clr;

    ram_sdp_be #(.A(4), .D(16), .B(8), .LAT(1), .WFIRST(1), .FILL(FILL_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
    );
    ram_sdp_be #(.A(4), .D(16), .B(8), .LAT(2), .WFIRST(0), .FILL(FILL_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
    );

    // Behavioural model: k=0 is dut_a (LAT 1, new data), k=1 is dut_b (LAT 2, old data)
    logic [15:0] m_mem [2][16];
    int          m_cnt [2];
    int          m_fidx [2];
    logic        m_vh [2][2];
    logic [15:0] m_dh [2][2];
    logic [15:0] m_last [2];
    logic        m_vexp [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [15:0] fill_of(input int k);
        return (k == 0) ? FILL_A : FILL_B;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        logic [15:0] r;
        r = o;
        if (be[0]) r[7:0]  = n[7:0];
        if (be[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 16;
            m_fidx[k] = 0;
            m_vh[k][0] = 1'b0; m_vh[k][1] = 1'b0;
            m_dh[k][0] = '0;   m_dh[k][1] = '0;
            m_last[k] = '0;
            m_vexp[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic        nv;
        logic [15:0] nd;
        for (int k = 0; k < 2; k++) begin
            nv = 1'b0;
            nd = '0;
            if (m_cnt[k] > 0) begin
                m_mem[k][m_fidx[k]] = fill_of(k);
                m_fidx[k] = m_fidx[k] + 1;
                m_cnt[k]  = m_cnt[k] - 1;
            end else begin
                if (re) begin
                    nv = 1'b1;
                    nd = m_mem[k][raddr];
                    if (k == 0 && we && waddr == raddr) nd = merge(nd, wdata, wbe);
                end
                if (we) m_mem[k][waddr] = merge(m_mem[k][waddr], wdata, wbe);
                if (clr) begin
                    m_cnt[k]  = 16;
                    m_fidx[k] = 0;
                end
            end
            m_vh[k][1] = m_vh[k][0]; m_dh[k][1] = m_dh[k][0];
            m_vh[k][0] = nv;         m_dh[k][0] = nd;
            m_vexp[k] = m_vh[k][lat_of(k)-1];
            if (m_vexp[k]) m_last[k] = m_dh[k][lat_of(k)-1];
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_busy_a",   {15'd0, bus_a.busy},   {15'd0, m_cnt[0] > 0});
            check("cmp_rvalid_a", {15'd0, bus_a.rvalid}, {15'd0, m_vexp[0]});
            check("cmp_rdata_a",  bus_a.rdata,           m_last[0]);
            check("cmp_busy_b",   {15'd0, bus_b.busy},   {15'd0, m_cnt[1] > 0});
            check("cmp_rvalid_b", {15'd0, bus_b.rvalid}, {15'd0, m_vexp[1]});
            check("cmp_rdata_b",  bus_b.rdata,           m_last[1]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        we = 1'b0; re = 1'b0; clr = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        we = 1'b1; waddr = a; wdata = d; wbe = be;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_lit(input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
        re = 1'b1; raddr = a;
        @(negedge clk);
        re = 1'b0;
        check("lit_rvalid_a", {15'd0, bus_a.rvalid}, 16'd1);
        check("lit_rdata_a",  bus_a.rdata, ea);
        @(negedge clk);
        check("lit_rvalid_b", {15'd0, bus_b.rvalid}, 16'd1);
        check("lit_rdata_b",  bus_b.rdata, eb);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (bus_a.busy && n < 100) begin
            we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
            waddr = 4'($urandom); raddr = 4'($urandom);
            wdata = 16'($urandom); wbe = 2'($urandom);
            @(negedge clk);
            n++;
        end
        idle();
        check(name, 16'(n), 16'd16);
    endtask

    initial begin
        int ca, cb, first_b;
        idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        count_busy("busy_after_reset");

        for (int i = 0; i < 16; i++) begin
            re = 1'b1; raddr = i[3:0];
            @(negedge clk);
        end
        idle();
        repeat (2) @(negedge clk);
        rd_lit(4'd9, FILL_A, FILL_B);

        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hABCD, 2'b10);
        rd_lit(4'd3, 16'hAB34, 16'hAB34);
        wr(4'd3, 16'hFFFF, 2'b00);
        rd_lit(4'd3, 16'hAB34, 16'hAB34);

        wr(4'd5, 16'h1111, 2'b11);
        we = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; wbe = 2'b11;
        re = 1'b1; raddr = 4'd5;
        @(negedge clk);
        idle();
        check("rdw_new_a", bus_a.rdata, 16'hBEEF);
        @(negedge clk);
        check("rdw_old_b", bus_b.rdata, 16'h1111);
        rd_lit(4'd5, 16'hBEEF, 16'hBEEF);

        ca = 0; cb = 0; first_b = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin re = 1'b1; raddr = i[3:0]; end
            else re = 1'b0;
            @(negedge clk);
            if (bus_a.rvalid) ca++;
            if (bus_b.rvalid) begin
                cb++;
                if (first_b == 0) first_b = i + 1;
            end
        end
        idle();
        check("burst_count_a", 16'(ca), 16'd4);
        check("burst_count_b", 16'(cb), 16'd4);
        check("burst_first_b", 16'(first_b), 16'd2);

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 99) == 0);
            waddr = 4'($urandom); raddr = 4'($urandom);
            wdata = 16'($urandom); wbe = 2'($urandom);
            @(negedge clk);
        end
        idle();
        while (bus_a.busy) @(negedge clk);
        repeat (2) @(negedge clk);

        we = 1'b1; waddr = 4'd7; wdata = 16'hC0DE; wbe = 2'b11;
        re = 1'b1; raddr = 4'd7; clr = 1'b1;
        @(negedge clk);
        idle();
        check("clr_rd_a", bus_a.rdata, 16'hC0DE);
        check("clr_busy_a", {15'd0, bus_a.busy}, 16'd1);
        count_busy("busy_after_clr");
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; raddr = i[3:0];
            @(negedge clk);
        end
        idle();
        repeat (2) @(negedge clk);
        rd_lit(4'd7, FILL_A, FILL_B);

        wr(4'd2, 16'h3C3C, 2'b11);
        rd_lit(4'd2, 16'h3C3C, 16'h3C3C);
        clr = 1'b1;
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_rvalid_a", {15'd0, bus_a.rvalid}, 16'd0);
        check("rst_rdata_a",  bus_a.rdata, 16'd0);
        check("rst_rvalid_b", {15'd0, bus_b.rvalid}, 16'd0);
        check("rst_rdata_b",  bus_b.rdata, 16'd0);
        check("rst_busy_a",   {15'd0, bus_a.busy}, 16'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        count_busy("busy_after_midreset");
        rd_lit(4'd0, FILL_A, FILL_B);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be.md
# ram_sdp_be

Parametrised simple-dual-port synchronous RAM: one write port with byte-lane enables, one independent read port, selectable read-during-write behaviour, and 1- or 2-cycle read latency. A built-in clear engine fills the array with a constant after reset and on request, so contents are defined before first use. Used as the general-purpose frame/scratch memory for video and CPU blocks, replacing the single-port RAMs where concurrent read and write are needed.

## Interface
- A, 10, address bits; depth = 2^A words
- D, 8, data bits; must be a multiple of B
- B, 8, bits per byte lane; lanes L = D/B
- LAT, 1, read latency in cycles; legal values 1 or 2
- WFIRST, 1, same-address read-during-write: 1 = return new data, 0 = return old data
- FILL, 0, D-bit word written by the clear engine
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  A  write address
- wdata  in  D  write data
- wbe  in  L  byte-lane enables; lane i covers wdata[i*B +: B]
- re  in  1  read enable
- raddr  in  A  read address
- rdata  out  D  read data, held until the next valid read
- rvalid  out  1  one-cycle pulse, rdata valid
- clr  in  1  request full-array fill with FILL
- busy  out  1  clear engine active; user writes and reads ignored

## Operation
- FSM states: CLEAR, IDLE. Reset enters CLEAR with fill address = 0.
- CLEAR: each cycle writes FILL to fill address, increments it; after writing address 2^A-1 → IDLE. busy = 1 in CLEAR.
- IDLE: busy = 0. clr sampled high → CLEAR with fill address 0.
- clr while in CLEAR ignored (no restart).
- Write in IDLE: we=1 updates only lanes with wbe[i]=1; we=1 with wbe=0 is a no-op.
- Read in IDLE: re=1 launches a read of raddr; result appears LAT cycles later with rvalid=1.
- we/re during CLEAR ignored: no memory change, no rvalid.
- Read-during-write, raddr == waddr, same edge: WFIRST=1 → rdata = old word with enabled lanes replaced by wdata; WFIRST=0 → old word. Different addresses never interact.
- Reads launched before CLEAR starts complete normally (pipeline drains).
- Memory array has no reset; only the clear engine defines contents.

## Timing
- Reset values: rdata = 0, rvalid = 0, busy = 1.
- After reset_n deasserts, first rising edge writes address 0; busy falls after the edge writing 2^A-1: busy high for exactly 2^A cycles.
- clr high at edge t (IDLE): busy = 1 after t; fill writes at edges t+1 … t+2^A; busy = 0 after edge t+2^A.
- we/re/clr all high at edge t in IDLE: the user write and read at t are performed; fill then overwrites from t+1.
- re at edge t → rvalid/rdata after edge t+LAT; back-to-back reads give one result per cycle.
- LAT=2 adds one output register after the array read; no bypass.
- reset_n asserted mid-clear or mid-read: FSM back to CLEAR/address 0, rvalid and pipeline cleared immediately; array contents unspecified until new clear completes.
- Fill address wraps from 2^A-1 only on exit; never revisits address 0 in one pass.

## Structure
- Shared package ram_pkg: FSM state enum (CLEAR, IDLE), legal LAT values, WFIRST mode constants; parameter legality (D % B == 0, LAT ∈ {1,2}) checked at elaboration.
- Sub-module ram_sdp_core: bare storage array, byte-lane write, synchronous read with WFIRST handling; no reset. Top level holds clear FSM, port muxing, latency pipeline, rvalid.

## Test plan
- Reset release, A=4: busy high exactly 16 cycles; then reading all 16 addresses returns FILL (e.g. 8'hA5), rvalid one cycle after each re (LAT=1).
- D=16, B=8: write 16'h1234 all lanes to addr 3, then 16'hABCD with wbe=2'b10 → read addr 3 returns 16'hAB34.
- Same-address read and write 16'hBEEF over old 16'h1111: WFIRST=1 returns 16'hBEEF, WFIRST=0 returns 16'h1111; next read returns 16'hBEEF.
- LAT=2: reads on 4 consecutive cycles to addrs 0..3 → 4 consecutive rvalid pulses starting 2 cycles after the first re, data in order.
- clr with we and re same cycle: that write lands and read returns written data; busy 2^A cycles; we/re during busy produce no change and no rvalid; afterwards all words = FILL.
- reset_n pulsed low mid-clear: rvalid and rdata drop to 0 asynchronously; busy remains high through reset and a full 2^A-cycle clear restarts from address 0.
